softusb_dmem_arbiter: RTL and testbench

//  Shares the single USB-side byte port of the softusb data memory between two requesters.

---
 rtl/softusb_dmem_arbiter_if.sv | 51 +++++
 rtl/softusb_dmem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_softusb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/softusb_dmem_arbiter_if.sv
// softusb_dmem_arbiter_if
//   Bundles the two requester ports and the RAM-side pins of the softusb
//   data-memory arbiter.
//   slave  : arbiter view (requests in, grants/read data out, drives RAM pins)
//   master : environment view (CPU/DMA requesters plus the RAM block)
//   Port A : a_req/a_we/a_adr/a_dat_i in, a_stall/a_valid/a_dat_o out
//   Port B : b_req/b_we/b_adr/b_dat_i/b_lock in, b_ack/b_valid/b_dat_o out
//   RAM    : dmem_we/dmem_a/dmem_di out, dmem_do in (1-cycle read latency)
interface softusb_dmem_arbiter_if #(
  parameter int dmem_width = 13
);
  logic                  a_req;
  logic                  a_we;
  logic [dmem_width-1:0] a_adr;
  logic [7:0]            a_dat_i;
  logic                  a_stall;
  logic                  a_valid;
  logic [7:0]            a_dat_o;

  logic                  b_req;
  logic                  b_we;
  logic [dmem_width-1:0] b_adr;
  logic [7:0]            b_dat_i;
  logic                  b_lock;
  logic                  b_ack;
  logic                  b_valid;
  logic [7:0]            b_dat_o;

  logic                  dmem_we;
  logic [dmem_width-1:0] dmem_a;
  logic [7:0]            dmem_di;
  logic [7:0]            dmem_do;

  modport slave (
    input  a_req, a_we, a_adr, a_dat_i,
    output a_stall, a_valid, a_dat_o,
    input  b_req, b_we, b_adr, b_dat_i, b_lock,
    output b_ack, b_valid, b_dat_o,
    output dmem_we, dmem_a, dmem_di,
    input  dmem_do
  );

  modport master (
    output a_req, a_we, a_adr, a_dat_i,
    input  a_stall, a_valid, a_dat_o,
    output b_req, b_we, b_adr, b_dat_i, b_lock,
    input  b_ack, b_valid, b_dat_o,
    input  dmem_we, dmem_a, dmem_di,
    output dmem_do
  );
endinterface

// File: rtl/softusb_dmem_arbiter.sv
// softusb_dmem_arbiter
//   Shares the single USB-side byte port of the softusb data memory between
//   the navre CPU (port A, priority) and the SIE/DMA engine (port B).
//   One access per usb_clk cycle; read data returns one cycle later on both
//   *_dat_o buses, qualified by *_valid. A starvation guard forces B through
//   after max_wait refused cycles; b_lock lets B hold the port for up to
//   burst_max consecutive grants.
// Ports
//   usb_clk, usb_rst_n : clock, asynchronous active-low reset
//   bus                : softusb_dmem_arbiter_if.slave (A, B and RAM pins)
//   stat_clr, stat_conflicts : only with SOFTUSB_DMEM_ARB_STATS_EN defined
// Optional feature
//   `define SOFTUSB_DMEM_ARB_STATS_EN adds a saturating 16-bit count of
//   cycles in which both ports request.
//
// state    | meaning
// ST_PRIO  | A has priority; B served only when A idle; refusals counted
// ST_FORCE | B starved for max_wait cycles; B wins this cycle
// ST_BURST | B holds the port while b_lock stays high; A stalls
module softusb_dmem_arbiter #(
  parameter int dmem_width = 13,
  parameter int max_wait   = 8,
  parameter int burst_max  = 4
) (
  input  logic usb_clk,
  input  logic usb_rst_n,
  softusb_dmem_arbiter_if.slave bus
`ifdef SOFTUSB_DMEM_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_conflicts
`endif
);

  typedef enum logic [1:0] {ST_PRIO, ST_FORCE, ST_BURST} state_t;

  localparam logic [7:0] WAIT_LAST  = 8'(max_wait - 1);
  localparam logic [3:0] BURST_LAST = 4'(burst_max - 1);
  // With burst_max == 1 the entering grant is already the whole burst.
  localparam bit BURST_OK = (burst_max > 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       a_valid_q, a_valid_d;
  logic       b_valid_q, b_valid_d;
  logic       gnt_a, gnt_b;
  logic [dmem_width-1:0] adr_mux;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      ST_PRIO: begin
        gnt_a = bus.a_req;
        gnt_b = bus.b_req & ~bus.a_req;
      end
      ST_FORCE: begin
        gnt_b = bus.b_req;
        gnt_a = bus.a_req & ~bus.b_req;
      end
      ST_BURST: gnt_b = bus.b_req & bus.b_lock;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_PRIO: begin
        if (gnt_b || !bus.b_req) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_FORCE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (gnt_b && bus.b_lock && BURST_OK) begin
          state_d     = ST_BURST;
          burst_cnt_d = 4'd1;
        end
      end
      ST_FORCE: begin
        wait_cnt_d = '0;
        if (gnt_b && bus.b_lock && BURST_OK) begin
          state_d     = ST_BURST;
          burst_cnt_d = 4'd1;
        end else begin
          state_d     = ST_PRIO;
          burst_cnt_d = '0;
        end
      end
      ST_BURST: begin
        wait_cnt_d = '0;
        if (gnt_b) burst_cnt_d = burst_cnt_q + 4'd1;
        // Leave on the grant that completes the burst, so A never sees an
        // extra dead cycle after the last B access.
        if (!gnt_b || burst_cnt_q == BURST_LAST) begin
          state_d     = ST_PRIO;
          burst_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_PRIO;
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
      end
    endcase
    a_valid_d = gnt_a & ~bus.a_we;
    b_valid_d = gnt_b & ~bus.b_we;
  end

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      state_q     <= ST_PRIO;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
    end
  end

  // Idle cycles present A's address so the RAM sees a stable bus.
  assign adr_mux      = gnt_b ? bus.b_adr : bus.a_adr;
  assign bus.dmem_a   = adr_mux;
  assign bus.dmem_di  = gnt_b ? bus.b_dat_i : bus.a_dat_i;
  assign bus.dmem_we  = (gnt_a & bus.a_we) | (gnt_b & bus.b_we);
  assign bus.a_stall  = bus.a_req & ~gnt_a;
  assign bus.b_ack    = gnt_b;
  assign bus.a_valid  = a_valid_q;
  assign bus.b_valid  = b_valid_q;
  assign bus.a_dat_o  = bus.dmem_do;
  assign bus.b_dat_o  = bus.dmem_do;

`ifdef SOFTUSB_DMEM_ARB_STATS_EN
  logic [15:0] conflicts_q, conflicts_d;

  always_comb begin
    conflicts_d = conflicts_q;
    if (stat_clr)
      conflicts_d = '0;
    else if (bus.a_req && bus.b_req && conflicts_q != 16'hFFFF)
      conflicts_d = conflicts_q + 16'd1;
  end

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) conflicts_q <= '0;
    else            conflicts_q <= conflicts_d;
  end

  assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_softusb_dmem_arbiter.sv
module tb_softusb_dmem_arbiter;
  localparam int AW   = 13;
  localparam int MAXW = 8;
  localparam int BMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softusb_dmem_arbiter_if #(.dmem_width(AW)) bus();

`ifdef SOFTUSB_DMEM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_conflicts;
`endif

  softusb_dmem_arbiter #(.dmem_width(AW), .max_wait(MAXW), .burst_max(BMAX)) dut (
    .usb_clk   (clk),
    .usb_rst_n (rst_n),
    .bus       (bus)
`ifdef SOFTUSB_DMEM_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_conflicts (stat_conflicts)
`endif
  );

  // RAM block: synchronous write, registered read of the pre-write value.
  logic [7:0] ram [0:8191];
  always @(posedge clk) begin
    if (bus.dmem_we) ram[bus.dmem_a] <= bus.dmem_di;
    bus.dmem_do <= ram[bus.dmem_a];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Reference model: B's consecutive refusals and grants used in a burst.
  logic [7:0] ref_mem [0:8191];
  int         m_refused = 0;
  int         m_burst   = 0;
  logic       m_avld = 1'b0, m_bvld = 1'b0;
  logic [7:0] m_rd = 8'h00;

  task automatic model_reset();
    m_refused = 0; m_burst = 0; m_avld = 1'b0; m_bvld = 1'b0;
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [12:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [12:0] ba, input logic [7:0] bd,
                       input logic bl);
    bus.a_req = ar; bus.a_we = aw; bus.a_adr = aa; bus.a_dat_i = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_adr = ba; bus.b_dat_i = bd; bus.b_lock = bl;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0);
  endtask

  // Called at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic step();
    logic ga, gb, e_we;
    logic [12:0] e_a;
    logic [7:0]  e_di, rd_next;
    @(negedge clk);
    if (m_burst > 0) begin
      ga = 1'b0; gb = bus.b_req & bus.b_lock;
    end else if (m_refused >= MAXW) begin
      gb = bus.b_req; ga = bus.a_req & ~bus.b_req;
    end else begin
      ga = bus.a_req; gb = bus.b_req & ~bus.a_req;
    end
    e_we = ga ? bus.a_we : (gb ? bus.b_we : 1'b0);
    e_a  = gb ? bus.b_adr : bus.a_adr;
    e_di = gb ? bus.b_dat_i : bus.a_dat_i;
    chk("a_stall", bus.a_stall, bus.a_req & ~ga);
    chk("b_ack",   bus.b_ack, gb);
    chk("dmem_we", bus.dmem_we, e_we);
    chk("dmem_a",  bus.dmem_a, e_a);
    chk("dmem_di", bus.dmem_di, e_di);
    chk("a_valid", bus.a_valid, m_avld);
    chk("b_valid", bus.b_valid, m_bvld);
    if (m_avld) chk("a_dat_o", bus.a_dat_o, m_rd);
    if (m_bvld) chk("b_dat_o", bus.b_dat_o, m_rd);
    if (m_burst > 0) begin
      m_refused = 0;
      if (gb) m_burst++;
      if (!gb || m_burst == BMAX) m_burst = 0;
    end else if (m_refused >= MAXW) begin
      m_refused = 0;
      if (gb && bus.b_lock && BMAX > 1) m_burst = 1;
    end else if (gb) begin
      m_refused = 0;
      if (bus.b_lock && BMAX > 1) m_burst = 1;
    end else if (bus.b_req) begin
      m_refused++;
    end else begin
      m_refused = 0;
    end
    rd_next = ref_mem[e_a];
    if (e_we) ref_mem[e_a] = e_di;
    m_rd   = rd_next;
    m_avld = ga & ~bus.a_we;
    m_bvld = gb & ~bus.b_we;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic ar, aw; logic [12:0] aa; logic [7:0] ad;
    logic br, bw; logic [12:0] ba; logic [7:0] bd; logic bl;
    logic e_stall, e_ack, e_we; logic [12:0] e_a; logic [7:0] e_di;
    logic e_avld, e_bvld; logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int first_ack, last_ack, n_ack;
    logic stall9, stall10, ack10, stall13;

    //          ar   aw   aa       ad     br   bw   ba       bd     bl   stl  ack  we   e_a      e_di   av   bv   rd
    tbl[0] = '{1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,8'h00};
    tbl[1] = '{1'b1,1'b0,13'h010,8'h99, 1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,13'h010,8'h99, 1'b1,1'b0,init_byte(16)};
    tbl[2] = '{1'b0,1'b0,13'h1AB,8'h33, 1'b1,1'b1,13'h100,8'h55, 1'b0,1'b0,1'b1,1'b1,13'h100,8'h55, 1'b0,1'b0,8'h00};
    tbl[3] = '{1'b1,1'b1,13'h020,8'h77, 1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,1'b0,1'b1,13'h020,8'h77, 1'b0,1'b0,8'h00};
    tbl[4] = '{1'b1,1'b0,13'h030,8'h01, 1'b1,1'b1,13'h100,8'hAA, 1'b0,1'b0,1'b0,1'b0,13'h030,8'h01, 1'b1,1'b0,init_byte(48)};
    tbl[5] = '{1'b1,1'b1,13'h040,8'h12, 1'b1,1'b0,13'h050,8'h00, 1'b0,1'b0,1'b0,1'b1,13'h040,8'h12, 1'b0,1'b0,8'h00};
    tbl[6] = '{1'b0,1'b0,13'h005,8'h00, 1'b1,1'b0,13'h1FFF,8'h3C, 1'b0,1'b0,1'b1,1'b0,13'h1FFF,8'h3C, 1'b0,1'b1,init_byte(8191)};
    tbl[7] = '{1'b1,1'b0,13'h100,8'h00, 1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,13'h100,8'h00, 1'b1,1'b0,8'h55};
    tbl[8] = '{1'b0,1'b0,13'h000,8'h00, 1'b1,1'b1,13'h0AB,8'hC3, 1'b1,1'b0,1'b1,1'b1,13'h0AB,8'hC3, 1'b0,1'b0,8'h00};
    tbl[9] = '{1'b1,1'b0,13'h0AB,8'h00, 1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,1'b0,1'b0,13'h0AB,8'h00, 1'b1,1'b0,8'hC3};

    for (int i = 0; i < 8192; i++) begin
      ram[i] = init_byte(i);
      ref_mem[i] = init_byte(i);
    end

    // Reset state
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst a_valid", bus.a_valid, 1'b0);
    chk("rst b_valid", bus.b_valid, 1'b0);
    chk("rst a_stall", bus.a_stall, 1'b0);
    chk("rst b_ack",   bus.b_ack, 1'b0);
    chk("rst dmem_we", bus.dmem_we, 1'b0);
    rst_n = 1'b1;
    model_reset();

    // Directed vectors, each followed by an idle cycle to see read return
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd, tbl[i].bl);
      #3;
      chk("tbl a_stall", bus.a_stall, tbl[i].e_stall);
      chk("tbl b_ack",   bus.b_ack,   tbl[i].e_ack);
      chk("tbl dmem_we", bus.dmem_we, tbl[i].e_we);
      chk("tbl dmem_a",  bus.dmem_a,  tbl[i].e_a);
      chk("tbl dmem_di", bus.dmem_di, tbl[i].e_di);
      step();
      drive_idle();
      chk("tbl a_valid", bus.a_valid, tbl[i].e_avld);
      chk("tbl b_valid", bus.b_valid, tbl[i].e_bvld);
      if (tbl[i].e_avld) chk("tbl a_dat_o", bus.a_dat_o, tbl[i].e_rd);
      if (tbl[i].e_bvld) chk("tbl b_dat_o", bus.b_dat_o, tbl[i].e_rd);
      step();
    end

    // Starvation guard: B forced through on cycle max_wait+1
    first_ack = 0; stall9 = 1'b0; stall10 = 1'b1; ack10 = 1'b1;
    drive(1'b1, 1'b0, 13'h010, 8'h00, 1'b1, 1'b0, 13'h020, 8'h00, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      #3;
      if (bus.b_ack && first_ack == 0) first_ack = c;
      if (c == 9) stall9 = bus.a_stall;
      if (c == 10) begin stall10 = bus.a_stall; ack10 = bus.b_ack; end
      step();
    end
    chk("force first_ack", 32'(first_ack), 32'(MAXW + 1));
    chk("force a_stall",   stall9, 1'b1);
    chk("force a_resume",  stall10, 1'b0);
    chk("force b_ack_off", ack10, 1'b0);
    drive_idle(); step();

    // Locked burst under contention: force grant plus burst_max-1 burst grants
    n_ack = 0; first_ack = 0; last_ack = 0; stall13 = 1'b1;
    drive(1'b1, 1'b0, 13'h011, 8'h00, 1'b1, 1'b1, 13'h300, 8'h5A, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      #3;
      if (bus.b_ack) begin
        n_ack++;
        if (first_ack == 0) first_ack = c;
        last_ack = c;
      end
      if (c == 13) stall13 = bus.a_stall;
      step();
    end
    chk("burst n_ack", 32'(n_ack), 32'(BMAX));
    chk("burst first", 32'(first_ack), 32'(MAXW + 1));
    chk("burst last",  32'(last_ack), 32'(MAXW + BMAX));
    chk("burst a_resume", stall13, 1'b0);
    drive_idle(); step();

    // Reset while in BURST
    drive(1'b0, 1'b0, 13'h000, 8'h00, 1'b1, 1'b0, 13'h200, 8'h00, 1'b1);
    step();
    drive(1'b1, 1'b0, 13'h012, 8'h00, 1'b1, 1'b1, 13'h201, 8'hE7, 1'b1);
    #1;
    chk("preRst b_ack",   bus.b_ack, 1'b1);
    chk("preRst dmem_we", bus.dmem_we, 1'b1);
    chk("preRst b_valid", bus.b_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midRst b_ack",   bus.b_ack, 1'b0);
    chk("midRst dmem_we", bus.dmem_we, 1'b0);
    chk("midRst b_valid", bus.b_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    #2;
    chk("postRst a_stall", bus.a_stall, 1'b0);
    chk("postRst b_ack",   bus.b_ack, 1'b0);
    step();
    drive_idle(); step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3), 13'($urandom_range(0, 8191)), 8'($urandom),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 3), 13'($urandom_range(0, 8191)), 8'($urandom),
            1'($urandom_range(0, 1)));
      step();
    end
    drive_idle(); step();

`ifdef SOFTUSB_DMEM_ARB_STATS_EN
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    chk("stat cleared", stat_conflicts, 16'd0);
    drive(1'b1, 1'b0, 13'h001, 8'h00, 1'b1, 1'b0, 13'h002, 8'h00, 1'b0);
    for (int n = 0; n < 300; n++) step();
    drive_idle();
    chk("stat 300", stat_conflicts, 16'd300);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    chk("stat clr", stat_conflicts, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
